// File: rtl/rr_arbiter_16_if.sv
// Handshake bundle between requesters and the 16-way round-robin arbiter.
// master: requester side (drives req/req_mask/done). slave: arbiter side.
interface rr_arbiter_16_if;
    logic [15:0] req;
    logic [15:0] req_mask;
    logic        done;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_oh;
    logic        timeout;

    modport master (
        output req, req_mask, done,
        input  grant_valid, grant_idx, grant_oh, timeout
    );

    modport slave (
        input  req, req_mask, done,
        output grant_valid, grant_idx, grant_oh, timeout
    );
endinterface

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with a hold-until-release grant and a
// mandatory one-cycle turnaround between owners.
// Optional feature: define ARB_TIMEOUT_EN to force release of a grant after
// TIMEOUT_CYCLES cycles (legal 2..255). The timeout pulse is asserted in the
// last grant cycle itself. Without the macro, timeout is tied to 0.
module rr_arbiter_16 #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic            clk,
    input logic            rst_n,
    rr_arbiter_16_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  grant_idx_q, grant_idx_d;
    logic [15:0] grant_oh_q, grant_oh_d;
    logic        grant_valid_q, grant_valid_d;

    logic [15:0] eligible;
    logic        pick_found;
    logic [3:0]  pick_idx;
    logic        release_req;
    logic        force_rel;

    // Rotating priority search: first eligible requester at or after ptr.
    always_comb begin
        eligible   = bus.req & bus.req_mask;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (!pick_found && eligible[ptr_q + 4'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 4'(i);
            end
        end
    end

    // Owner gives up the resource by pulsing done or dropping its request.
    always_comb begin
        release_req = bus.done || !bus.req[grant_idx_q];
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // Grant-age counter: held at zero outside GRANT so it starts clean on entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_GRANT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Grant-age counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A normal release in the same cycle wins, so the pulse only marks forced releases.
    always_comb begin
        force_rel = (state_q == S_GRANT) && !release_req && (cnt_q == CNT_LAST);
    end
`else
    logic [7:0] timeout_cycles_unused;

    // No timeout hardware in this build.
    always_comb begin
        timeout_cycles_unused = 8'(TIMEOUT_CYCLES);
        force_rel             = 1'b0;
    end
`endif

    // Next-state and registered grant outputs.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        grant_oh_d    = grant_oh_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_valid_d = 1'b1;
                    grant_idx_d   = pick_idx;
                    grant_oh_d    = 16'h0001 << pick_idx;
                    state_d       = S_GRANT;
                end else begin
                    grant_valid_d = 1'b0;
                    grant_idx_d   = '0;
                    grant_oh_d    = '0;
                end
            end
            S_GRANT: begin
                if (release_req || force_rel) begin
                    grant_valid_d = 1'b0;
                    grant_idx_d   = '0;
                    grant_oh_d    = '0;
                    ptr_d         = grant_idx_q + 4'd1;
                    state_d       = S_TURN;
                end
            end
            S_TURN: begin
                grant_valid_d = 1'b0;
                grant_idx_d   = '0;
                grant_oh_d    = '0;
                state_d       = S_IDLE;
            end
            default: begin
                grant_valid_d = 1'b0;
                grant_idx_d   = '0;
                grant_oh_d    = '0;
                state_d       = S_IDLE;
            end
        endcase
    end

    // State, pointer and grant registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            grant_oh_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            grant_oh_q    <= grant_oh_d;
        end
    end

    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_oh    = grant_oh_q;
    assign bus.timeout     = force_rel;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: reset, rotation, wrap, masking,
// mid-grant reset, and (with ARB_TIMEOUT_EN) forced release.
module tb_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    rr_arbiter_16_if bus_if ();

    rr_arbiter_16 #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [3:0] idx, input logic to);
        logic [15:0] oh;
        logic [3:0]  eidx;
        eidx = v ? idx : 4'd0;
        oh   = v ? (16'h0001 << idx) : 16'h0000;
        n_vec++;
        assert (bus_if.grant_valid === v && bus_if.grant_idx === eidx &&
                bus_if.grant_oh === oh && bus_if.timeout === to)
        else begin
            n_bad++;
            $error("FAIL %s: observed valid=%b idx=%0d oh=%h timeout=%b, expected valid=%b idx=%0d oh=%h timeout=%b",
                   tag, bus_if.grant_valid, bus_if.grant_idx, bus_if.grant_oh, bus_if.timeout,
                   v, eidx, oh, to);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus_if.req      = '0;
        bus_if.req_mask = '0;
        bus_if.done     = 1'b0;
        step();
        step();
        expect_out("reset", 1'b0, 4'd0, 1'b0);

        // Single requester 0, released by done; then ptr=1 selects 1 over 0.
        rst_n           = 1'b1;
        bus_if.req      = 16'h0001;
        bus_if.req_mask = 16'hFFFF;
        step();
        expect_out("t1_grant0", 1'b1, 4'd0, 1'b0);
        bus_if.done = 1'b1;
        step();
        expect_out("t1_release", 1'b0, 4'd0, 1'b0);
        bus_if.done = 1'b0;
        bus_if.req  = '0;
        step();
        expect_out("t1_idle", 1'b0, 4'd0, 1'b0);
        bus_if.done = 1'b1;
        step();
        expect_out("t1_done_in_idle", 1'b0, 4'd0, 1'b0);
        bus_if.done = 1'b0;
        bus_if.req  = 16'h0003;
        step();
        expect_out("t1_ptr1", 1'b1, 4'd1, 1'b0);
        bus_if.req = '0;
        step();
        step();

        // All requesting: 0..15 then wrap to 0, two dead cycles between grants.
        rst_n = 1'b0;
        step();
        expect_out("t2_reset", 1'b0, 4'd0, 1'b0);
        rst_n      = 1'b1;
        bus_if.req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            step();
            expect_out("t2_grant", 1'b1, 4'(k), 1'b0);
            bus_if.done = 1'b1;
            step();
            expect_out("t2_gap1", 1'b0, 4'd0, 1'b0);
            bus_if.done = 1'b0;
            step();
            expect_out("t2_gap2", 1'b0, 4'd0, 1'b0);
        end

        // Grant 14 then ptr=15: 15 wins, then wrap to 0.
        bus_if.req = 16'h4000;
        step();
        expect_out("t3_grant14", 1'b1, 4'd14, 1'b0);
        bus_if.req = 16'h8001;
        step();
        expect_out("t3_turn", 1'b0, 4'd0, 1'b0);
        step();
        expect_out("t3_idle", 1'b0, 4'd0, 1'b0);
        step();
        expect_out("t3_grant15", 1'b1, 4'd15, 1'b0);
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        step();
        step();
        expect_out("t3_wrap0", 1'b1, 4'd0, 1'b0);
        // done together with the owner's req dropping: one release, ptr=1.
        bus_if.done = 1'b1;
        bus_if.req  = 16'h8000;
        step();
        expect_out("t3_dual_release", 1'b0, 4'd0, 1'b0);
        bus_if.done = 1'b0;
        step();
        step();
        expect_out("t3_after_dual", 1'b1, 4'd15, 1'b0);
        bus_if.req = '0;
        step();
        step();

        // Masking: only 5 eligible; mask changes during GRANT ignored; mask=0 starves all.
        bus_if.req      = 16'h00F0;
        bus_if.req_mask = 16'h0020;
        step();
        expect_out("t4_grant5", 1'b1, 4'd5, 1'b0);
        bus_if.req_mask = 16'hFFFF;
        step();
        expect_out("t4_hold5", 1'b1, 4'd5, 1'b0);
        bus_if.req      = 16'hFFDF;
        bus_if.req_mask = 16'h0000;
        step();
        expect_out("t4_release5", 1'b0, 4'd0, 1'b0);
        bus_if.req = 16'hFFFF;
        for (int k = 0; k < 20; k++) begin
            step();
            expect_out("t4_masked", 1'b0, 4'd0, 1'b0);
        end
        bus_if.req_mask = 16'hFFFF;
        step();
        expect_out("t4_ptr_kept", 1'b1, 4'd6, 1'b0);

        // Reset while granted to 9: grant drops, ptr back to 0.
        bus_if.req = 16'h0200;
        step();
        step();
        step();
        expect_out("t5_grant9", 1'b1, 4'd9, 1'b0);
        rst_n = 1'b0;
        step();
        expect_out("t5_reset", 1'b0, 4'd0, 1'b0);
        rst_n      = 1'b1;
        bus_if.req = 16'h0201;
        step();
        expect_out("t5_grant0", 1'b1, 4'd0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after 4 grant cycles, then regrant; done on the last cycle suppresses the pulse.
        bus_if.req = '0;
        step();
        step();
        bus_if.req = 16'h0008;
        step();
        expect_out("t6_c1", 1'b1, 4'd3, 1'b0);
        step();
        expect_out("t6_c2", 1'b1, 4'd3, 1'b0);
        step();
        expect_out("t6_c3", 1'b1, 4'd3, 1'b0);
        step();
        expect_out("t6_c4_timeout", 1'b1, 4'd3, 1'b1);
        step();
        expect_out("t6_turn", 1'b0, 4'd0, 1'b0);
        step();
        expect_out("t6_idle", 1'b0, 4'd0, 1'b0);
        step();
        expect_out("t6_regrant", 1'b1, 4'd3, 1'b0);
        step();
        step();
        step();
        bus_if.done = 1'b1;
        #1;
        expect_out("t6_done_wins", 1'b1, 4'd3, 1'b0);
        step();
        bus_if.done = 1'b0;
        expect_out("t6_done_release", 1'b0, 4'd0, 1'b0);
`else
        // Without timeout the grant persists while req stays high.
        for (int k = 0; k < 10; k++) begin
            step();
            expect_out("t6_no_timeout", 1'b1, 4'd0, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
